enviar_fifo_ctrl: RTL and testbench

ENVIAR_FIFO_CTRL -- requirements
Module: enviar_fifo_ctrl

---
 rtl/enviar_fifo_ctrl.sv | 164 ++++++++++++++++
 tb/tb_enviar_fifo_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enviar_fifo_ctrl.sv
// Bus-mapped command FIFO for the command sender: queues (code, byte) entries written
// over the J1 bus and issues them one at a time, with a guaranteed idle gap between them.
module enviar_fifo_ctrl #(
   parameter int DEPTH   = 16,
   parameter int GAP     = 25,
   parameter int TIMEOUT = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic [3:0]  addr,
   input  logic        wr,
   input  logic        rd,
   input  logic [15:0] d_in,
   output logic [15:0] d_out,
   output logic        start,
   output logic [7:0]  datos,
   output logic [7:0]  comm_in,
   input  logic        bussy_e
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int TMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [3:0] ADDR_DATA = 4'h0;
   localparam logic [3:0] ADDR_STAT = 4'h2;
   localparam logic [3:0] ADDR_CTRL = 4'h4;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_BUSY, S_GAP} state_t;

   state_t        state, state_nx;
   logic [11:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [TW-1:0] timer;
   logic          empty, full, active;
   logic          ovf, badcode, tmo;
   logic          push_req, push_ok, pop, flush, clr_flags, code_bad;
   logic          load, tmo_set, start_nx;
   logic [15:0]   status;
   logic          unused_bits;

   // ---------------------------------------------------------------- bus decode
   assign push_req  = cs && wr && (addr == ADDR_DATA);
   assign flush     = cs && wr && (addr == ADDR_CTRL) && d_in[1];
   assign clr_flags = cs && wr && (addr == ADDR_CTRL) && d_in[0];
   assign code_bad  = (d_in[11:8] > 4'd9);
   assign unused_bits = ^d_in[15:12];

   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));
   assign active = (state != S_IDLE);

   // A pop frees a slot in the same edge, so a push into a full FIFO still lands.
   assign pop     = load && !empty;
   assign push_ok = push_req && !flush && !code_bad && (!full || pop);

   assign status = {2'b00, tmo, badcode, ovf, active, full, empty, 1'b0, 7'(count)};

   // ---------------------------------------------------------------- FIFO storage
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; validity is tracked by the pointers and count alone.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= d_in[11:0];
   end

   // ---------------------------------------------------------------- sticky flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf     <= 1'b0;
         badcode <= 1'b0;
         tmo     <= 1'b0;
      end else begin
         if (clr_flags) begin
            ovf     <= 1'b0;
            badcode <= 1'b0;
            tmo     <= 1'b0;
         end
         if (push_req && !flush && code_bad)                   badcode <= 1'b1;
         if (push_req && !flush && !code_bad && full && !pop) ovf     <= 1'b1;
         if (tmo_set)                                          tmo     <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- sequencer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: if (!empty) state_nx = S_LOAD;
         S_LOAD: state_nx = empty ? S_IDLE : S_REQ;  // entry flushed under us: nothing to send
         S_REQ: begin
            if (bussy_e)                           state_nx = S_BUSY;
            else if (timer == TW'(TIMEOUT - 1))    state_nx = S_GAP;
         end
         S_BUSY: if (!bussy_e) state_nx = S_GAP;
         S_GAP:  if (timer == TW'(GAP - 1)) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      load     = (state == S_LOAD);
      tmo_set  = (state == S_REQ) && (state_nx == S_GAP);
      start_nx = (state_nx == S_REQ) || (state_nx == S_BUSY);
   end

   // One shared timer: counts REQ cycles for the timeout and GAP cycles for the spacing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                   timer <= '0;
      else if (state_nx != state)                 timer <= '0;
      else if (state == S_REQ || state == S_GAP)  timer <= timer + TW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) start <= 1'b0;
      else      start <= start_nx;
   end

   // Payload registers hold the popped entry until the next pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         comm_in <= '0;
         datos   <= '0;
      end else if (pop) begin
         comm_in <= {4'h0, mem[rd_ptr][11:8]};
         datos   <= mem[rd_ptr][7:0];
      end
   end

   // ---------------------------------------------------------------- read port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           d_out <= '0;
      else if (cs && rd)  d_out <= (addr == ADDR_STAT) ? status : 16'h0000;
   end

endmodule

// File: tb/tb_enviar_fifo_ctrl.sv
// Randomised bench for enviar_fifo_ctrl: a queue-based reference model plus a reactive
// sender model, with directed scenarios for overflow, bad codes, timeout and reset.
module tb_enviar_fifo_ctrl;

   localparam int DEPTH   = 16;
   localparam int GAP     = 25;
   localparam int TIMEOUT = 1000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cs = 1'b0, wr = 1'b0, rd = 1'b0, bussy_e = 1'b0;
   logic [3:0]  addr = '0;
   logic [15:0] d_in = '0;
   logic [15:0] d_out;
   logic        start;
   logic [7:0]  datos, comm_in;

   always #5 clk = ~clk;

   enviar_fifo_ctrl #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .cs(cs), .addr(addr), .wr(wr), .rd(rd), .d_in(d_in),
      .d_out(d_out), .start(start), .datos(datos), .comm_in(comm_in), .bussy_e(bussy_e)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- reference model
   logic [11:0] q[$];
   bit          m_ovf, m_bad, m_tmo, m_active, m_start, m_acc;
   int          m_rise = -1, m_fall = -1, m_rise_at = 0;
   logic [7:0]  m_comm = '0, m_datos = '0;
   logic [15:0] m_dout = '0;
   int          cyc = 0, last_fall = -1;

   // Applies the rules for the upcoming clock edge, using the inputs currently driven.
   task automatic model_edge();
      int s;
      bit push, ctrl, flush, clr, pop, tmo_set, act_next;
      s        = q.size();
      push     = cs && wr && addr == 4'h0;
      ctrl     = cs && wr && addr == 4'h4;
      flush    = ctrl && d_in[1];
      clr      = ctrl && d_in[0];
      pop      = 1'b0;
      tmo_set  = 1'b0;
      act_next = m_active;
      if (cs && rd)
         m_dout = (addr == 4'h2) ? {2'b00, m_tmo, m_bad, m_ovf, m_active, (s == DEPTH), (s == 0), 1'b0, 7'(s)}
                                 : 16'h0000;
      if (cyc == m_rise) begin
         m_rise = -1;
         if (s > 0) begin
            pop       = 1'b1;
            m_comm    = {4'h0, q[0][11:8]};
            m_datos   = q[0][7:0];
            m_start   = 1'b1;
            m_acc     = 1'b0;
            m_rise_at = cyc;
         end else begin
            act_next = 1'b0;
         end
      end else if (!m_active && s > 0) begin
         m_rise   = cyc + 1;
         act_next = 1'b1;
      end else if (m_start) begin
         if (!m_acc && bussy_e) m_acc = 1'b1;
         else if (m_acc && !bussy_e) begin
            m_start = 1'b0;
            m_fall  = cyc;
         end else if (!m_acc && cyc - m_rise_at == TIMEOUT) begin
            m_start = 1'b0;
            m_fall  = cyc;
            tmo_set = 1'b1;
         end
      end else if (m_fall >= 0 && cyc == m_fall + GAP) begin
         act_next = 1'b0;
         m_fall   = -1;
      end
      if (pop) void'(q.pop_front());
      if (flush) q.delete();
      else if (push) begin
         if (d_in[11:8] > 4'd9)         m_bad = 1'b1;
         else if (s < DEPTH || pop)     q.push_back(d_in[11:0]);
         else                           m_ovf = 1'b1;
      end
      if (clr) begin
         m_ovf = 1'b0;
         m_bad = 1'b0;
         m_tmo = 1'b0;
      end
      if (tmo_set) m_tmo = 1'b1;
      m_active = act_next;
   endtask

   // ---------------------------------------------------------------- sender model
   int cfg_dmax = 3, cfg_lmin = 1, cfg_lmax = 20, cfg_never_pct = 0, snd_skip = 0;
   int snd_d, snd_l, snd_t;
   bit snd_armed = 1'b0, snd_never = 1'b0;

   task automatic sender();
      if (snd_armed && start !== 1'b1) begin
         snd_armed = 1'b0;
         bussy_e   = 1'b0;
      end else if (!snd_armed && start === 1'b1) begin
         snd_armed = 1'b1;
         snd_t     = 0;
         snd_d     = $urandom_range(cfg_dmax, 0);
         snd_l     = $urandom_range(cfg_lmax, cfg_lmin);
         snd_never = (snd_skip > 0) || ($urandom_range(99, 0) < cfg_never_pct);
         if (snd_skip > 0) snd_skip--;
      end
      if (snd_armed) begin
         bussy_e = !snd_never && snd_t >= snd_d && snd_t < snd_d + snd_l;
         snd_t++;
      end
   endtask

   // ---------------------------------------------------------------- cycle step
   task automatic step();
      logic prev_start;
      bit   prev_exp, did_rd;
      prev_start = start;
      prev_exp   = m_start;
      did_rd     = cs && rd;
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      if (start !== prev_start || m_start != prev_exp)
         check("start", 32'(start), 32'(m_start));
      if (m_start && !prev_exp) begin
         check("comm_in", 32'(comm_in), 32'(m_comm));
         check("datos", 32'(datos), 32'(m_datos));
      end
      if (did_rd) check("d_out", 32'(d_out), 32'(m_dout));
      if (prev_start === 1'b1 && start === 1'b0) last_fall = cyc;
      if (prev_start === 1'b0 && start === 1'b1 && last_fall >= 0)
         check("gap", 32'(cyc - last_fall >= GAP + 2), 32'd1);
      sender();
      cs   = 1'b0;
      wr   = 1'b0;
      rd   = 1'b0;
      addr = '0;
      d_in = '0;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
      cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
      step();
   endtask

   task automatic bus_read(input logic [3:0] a);
      cs = 1'b1; rd = 1'b1; addr = a;
      step();
   endtask

   task automatic run_until_start(input logic level, input int budget, input string tag, output int n);
      n = 0;
      while (start !== level && n < budget) begin
         step();
         n++;
      end
      check(tag, 32'(start === level), 32'd1);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((m_active || q.size() != 0 || start === 1'b1) && n < budget) begin
         step();
         n++;
      end
      check("drain", 32'(n < budget), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; d_in = '0; bussy_e = 1'b0;
      snd_armed = 1'b0; snd_skip = 0;
      q.delete();
      m_ovf = 1'b0; m_bad = 1'b0; m_tmo = 1'b0; m_active = 1'b0; m_start = 1'b0; m_acc = 1'b0;
      m_rise = -1; m_fall = -1; m_comm = '0; m_datos = '0; m_dout = '0; last_fall = -1;
      #1;
      check("rst_start", 32'(start), 32'd0);
      check("rst_datos", 32'(datos), 32'd0);
      check("rst_comm", 32'(comm_in), 32'd0);
      check("rst_dout", 32'(d_out), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   initial begin
      #(400000 * 10);
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- scenarios
   initial begin
      int n, hi, r;
      logic [3:0] a;

      // Reset state
      do_reset();
      bus_read(4'h2);
      check("status_rst", 32'(d_out), 32'h0100);

      // Single entry, sender busy for 200 clocks
      cfg_dmax = 3; cfg_lmin = 200; cfg_lmax = 200; cfg_never_pct = 0;
      bus_write(4'h0, 16'h0341);
      run_until_start(1'b1, 10, "rise036", n);
      check("lat036", 32'(n), 32'd2);
      check("comm036", 32'(comm_in), 32'd3);
      check("datos036", 32'(datos), 32'h41);
      run_until_start(1'b0, 400, "fall036", hi);
      check("hold036", 32'(hi >= 200), 32'd1);
      bus_read(4'h2);
      check("act036", 32'(d_out[10]), 32'd1);
      drain(100);
      bus_read(4'h2);
      check("idle036", 32'(d_out[10]), 32'd0);

      // Three entries back to back
      cfg_dmax = 4; cfg_lmin = 1; cfg_lmax = 10;
      for (int i = 1; i <= 3; i++) bus_write(4'h0, {4'h0, 4'(i), 8'($urandom_range(255, 0))});
      drain(600);

      // Overflow with the sender held off, then flush under an in-flight transaction
      snd_skip = 100;
      for (int i = 0; i < 17; i++)
         bus_write(4'h0, {4'h0, 4'($urandom_range(9, 0)), 8'($urandom_range(255, 0))});
      bus_write(4'h0, 16'h0512);
      bus_read(4'h2);
      check("full038", 32'(d_out[9]), 32'd1);
      check("count038", 32'(d_out[6:0]), 32'd16);
      check("ovf038", 32'(d_out[11]), 32'd1);
      bus_write(4'h4, 16'h0002);
      check("flush_keep", 32'(start), 32'd1);
      bus_read(4'h2);
      check("flush_cnt", 32'(d_out[6:0]), 32'd0);
      drain(1200);
      snd_skip = 0;

      // Bad code, flag clear, unmapped accesses
      bus_write(4'h0, 16'h0A55);
      bus_read(4'h2);
      check("bad039", 32'(d_out[12]), 32'd1);
      check("cnt039", 32'(d_out[6:0]), 32'd0);
      bus_write(4'h4, 16'h0001);
      bus_read(4'h2);
      check("clr039", 32'(d_out[13:11]), 32'd0);
      bus_write(4'h9, 16'h0123);
      bus_read(4'h6);
      bus_read(4'h2);

      // Timeout, then the next entry goes out
      cfg_dmax = 2; cfg_lmin = 1; cfg_lmax = 5; snd_skip = 1;
      bus_write(4'h0, 16'h0711);
      bus_write(4'h0, 16'h0822);
      run_until_start(1'b1, 10, "rise040", n);
      run_until_start(1'b0, TIMEOUT + 100, "fall040", hi);
      check("tmo_len", 32'(hi), 32'(TIMEOUT));
      bus_read(4'h2);
      check("tmo040", 32'(d_out[13]), 32'd1);
      run_until_start(1'b1, 100, "next040", n);
      check("comm040", 32'(comm_in), 32'd8);
      drain(200);

      // Asynchronous reset while the sender is busy
      cfg_dmax = 0; cfg_lmin = 100; cfg_lmax = 100;
      bus_write(4'h0, 16'h0199);
      run_until_start(1'b1, 10, "rise041", n);
      for (int i = 0; i < 5; i++) step();
      #2;
      do_reset();
      bus_read(4'h2);
      check("status041", 32'(d_out), 32'h0100);

      // Randomised traffic
      cfg_dmax = 5; cfg_lmin = 1; cfg_lmax = 40; cfg_never_pct = 3;
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(99, 0);
         if (r < 35)
            bus_write(4'h0, {4'h0, 4'($urandom_range(11, 0)), 8'($urandom_range(255, 0))});
         else if (r < 40)
            bus_read(4'h2);
         else if (r < 42)
            bus_read(4'($urandom_range(15, 0)));
         else if (r < 44)
            bus_write(4'h4, {14'h0, 2'($urandom_range(3, 0))});
         else if (r < 46) begin
            a = 4'($urandom_range(15, 0));
            if (a == 4'h0 || a == 4'h4) a = 4'hF;
            bus_write(a, 16'($urandom_range(65535, 0)));
         end else
            step();
      end
      cfg_never_pct = 0;
      drain(30000);
      bus_read(4'h2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
